// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end.
//
// Owns the fetch PC, issues one instruction-bus request at a time and keeps
// returned words, tagged with their PC, in a small FIFO for decode. A
// redirect replaces the PC and flushes the FIFO. If a request is still in
// flight, its response is drained and dropped in the STALE state.
//
// Optional feature macro: FETCH_PERF_EN (adds perf_fetch_cnt/perf_stall_cnt).
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   ireq              {valid, addr}: fetch request, held stable until data_ok
//   iresp             {addr_ok (unused), data_ok, data}: bus response
//   redirect_valid/pc pulse that replaces the fetch PC and flushes the FIFO
//   out_valid/pc/instr FIFO head to decode
//   out_ready         decode consumes the head when out_valid & out_ready
//   perf_fetch_cnt    (FETCH_PERF_EN) count of pushed instructions
//   perf_stall_cnt    (FETCH_PERF_EN) count of cycles with valid & ~data_ok

package fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] STALE = 2'd2;

  logic [1:0]       state;
  logic [63:0]      pc;
  logic [63:0]      req_pc;
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];

  logic             data_ok;
  logic             push, pop;
  logic [CNT_W-1:0] count_after;
  logic             room_idle, room_next;
  logic [63:0]      req_next;

  // addr_ok carries no meaning for this front end; a transaction ends on data_ok.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp.addr_ok;

  assign data_ok = iresp.data_ok;

  // A response is only kept in BUSY. In STALE it belongs to a flushed
  // request, and a redirect in the same cycle discards it as well.
  assign push        = (state == BUSY) && data_ok && !redirect_valid;
  assign pop         = out_valid && out_ready;
  assign count_after = count - CNT_W'(pop) + CNT_W'(push);
  assign req_next    = req_pc + 64'd4;

  // An outstanding request already owns a FIFO slot. So a new request is
  // issued only if its data can be pushed whatever decode does meanwhile.
  assign room_idle = count < CNT_W'(FIFO_DEPTH);
  assign room_next = count_after < CNT_W'(FIFO_DEPTH);

  assign ireq.valid = (state != IDLE);
  assign ireq.addr  = req_pc;

  assign out_valid = (count != '0);
  assign out_pc    = fifo_pc[rptr];
  assign out_instr = fifo_instr[rptr];

  // Request sequencing and fetch PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (room_idle) begin
            req_pc <= pc;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            // Without data_ok the bus still owes a response that must be drained.
            state <= data_ok ? IDLE : STALE;
          end else if (data_ok) begin
            pc <= req_next;
            if (room_next) req_pc <= req_next;
            else           state  <= IDLE;
          end
        end
        STALE: begin
          if (redirect_valid) pc <= redirect_pc;
          if (data_ok)        state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy. A redirect overrides both push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count_after;
    end
  end

  // FIFO storage. It needs no reset because count marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr]    <= req_pc;
      fifo_instr[wptr] <= iresp.data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)                    perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (ireq.valid && !data_ok)  perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the core.
- Owns the architectural fetch PC and drives the instruction bus (ireq/iresp) on behalf of the cpu pipeline.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from execute/branch logic; discards any stale in-flight bus response.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- ireq  output  ibus_req_t  fields valid (1), addr (64)
- iresp  input  ibus_resp_t  fields addr_ok (1), data_ok (1), data (32)
- redirect_valid  input  1  pulse; replace fetch PC and flush
- redirect_pc  input  64  new fetch target
- out_valid  output  1  FIFO head valid to decode
- out_pc  output  64  PC of head instruction
- out_instr  output  32  head instruction word
- out_ready  input  1  decode consumes head when out_valid & out_ready

Behaviour:
- Reset: asynchronous, active-high. Clears the FIFO (count 0, pointers 0), sets state IDLE, pc ← RESET_PC, ireq.valid 0, out_valid 0. Resetting mid-transaction drops the outstanding request with no further bus action.
- Bus rule: once ireq.valid rises, ireq.valid and ireq.addr stay stable until the cycle iresp.data_ok=1 (inclusive). iresp.addr_ok is ignored. A transaction completes on data_ok.
- ireq.addr = the registered request PC (req_pc). The low 2 bits are forwarded unchanged.
- States:
  - IDLE: ireq.valid=0. If no redirect this cycle and (count + 0) < FIFO_DEPTH: req_pc ← pc, go to BUSY (valid asserted the next cycle).
  - BUSY: ireq.valid=1.
    - data_ok, no redirect: push {req_pc, data}, pc ← req_pc+4. Back-to-back: if count_after < FIFO_DEPTH, req_pc ← req_pc+4 and stay BUSY; else go to IDLE.
    - redirect (with or without data_ok): pc ← redirect_pc, FIFO flushed. If data_ok is the same cycle, go to IDLE. Otherwise go to STALE.
  - STALE: ireq.valid=1, same addr held. On data_ok: discard data, go to IDLE. A further redirect in STALE only updates pc.
- Capacity check counts the FIFO entry reserved by the outstanding request, so a push is never lost. count_after = count − pop + push.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are allowed when full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Data returned with data_ok is never presented in the same cycle (no bypass; minimum latency data_ok → out_valid is 1 cycle).
- Redirect:
  - Has priority over push and pop that cycle. FIFO count ← 0; out_valid is 0 on the next cycle.
  - The first new request issues no earlier than the cycle after the redirect.
- PC arithmetic is 64-bit, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Outputs out_pc/out_instr are driven from the FIFO head and are don't-care when out_valid=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt (64): increments on each pushed instruction.
  - perf_stall_cnt (64): increments each cycle ireq.valid=1 & ~data_ok.
- Both counters reset to 0 and wrap on overflow.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then data_ok returned 1 cycle after each valid, out_ready=1 → ireq.addr sequence 8000_0000, 8000_0004, 8000_0008; out_pc follows one cycle after each data_ok, with matching out_instr.
- out_ready=0 with FIFO_DEPTH=2 → exactly 2 fetches complete, then ireq.valid=0. Raise out_ready → the head pops and the next fetch is at 8000_0008.
- data_ok delayed 5 cycles → ireq.valid/addr held constant for all 5 cycles; a single push occurs.
- Redirect to 8000_1000 while BUSY at 8000_0004, data_ok 3 cycles later → the 8000_0004 data is discarded, out_valid stays 0 until 8000_1000 returns, FIFO empty after the redirect.
- Redirect in the same cycle as data_ok → data dropped, next ireq.addr = redirect_pc, no STALE state entered.
- Async reset asserted mid-BUSY → ireq.valid and out_valid drop immediately; after release the fetch restarts at RESET_PC. With FETCH_PERF_EN, both counters read 0.
